hc_result_streamer: RTL and testbench

Downstream consumer of the hill-climbing optimiser. On the rising edge of the optimiser's `done` flag it snapshots the final fitness and solution vector. It then emits them as a framed byte stream over a valid/ready interface for the host link (UART/FIFO bridge). The optimiser may restart immediately after `done`, because the captured frame is held in an internal shadow register until fully sent.

---
 rtl/hc_stream_pkg.sv | 19 +
 rtl/hc_result_streamer.sv | 189 ++++++++++++++++++
 tb/tb_hc_result_streamer.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hc_stream_pkg.sv
// hc_stream_pkg: shared types and constants for the optimiser result streamer.
//   hc_stream_state_t : framing FSM state encoding
//   SYNC_BYTE         : first byte of every frame
//   HDR_BYTES         : header length (sync byte plus two fitness bytes)
package hc_stream_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StFitLo,
    StFitHi,
    StPayload,
    StCsum
  } hc_stream_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int unsigned HDR_BYTES = 3;

endpackage

// File: rtl/hc_result_streamer.sv
// hc_result_streamer: on the rising edge of the optimiser's done flag, snapshot the final
// fitness and solution and send them as a framed byte stream over valid/ready.
//
// Frame: A5, fitness[7:0], fitness[15:8] (zero-extended), solution bytes LSB first,
// plus a trailing XOR checksum byte when HC_STREAM_CHECKSUM_EN is defined.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   done_in             optimiser done level (rising edge captures)
//   fitness_in          optimiser best fitness (FIT_W bits)
//   solution_in         optimiser best solution (N_BITS bits)
//   m_data/m_valid/m_last/m_ready  byte stream to the host link
//   busy                a captured frame is still being sent
//   overrun             sticky: a done edge was dropped while busy
//   overrun_clr         synchronous clear of overrun (a simultaneous set wins)
//
// Build option: define HC_STREAM_CHECKSUM_EN to append the checksum byte.
module hc_result_streamer
  import hc_stream_pkg::*;
#(
  parameter int unsigned N_BITS = 1024,
  parameter int unsigned FIT_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              done_in,
  input  logic [FIT_W-1:0]  fitness_in,
  input  logic [N_BITS-1:0] solution_in,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              overrun,
  input  logic              overrun_clr
);

  localparam int unsigned NB    = N_BITS / 8;
  localparam int unsigned IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB - 1);

`ifdef HC_STREAM_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  if ((N_BITS % 8) != 0 || N_BITS < 8) begin : gen_bad_n_bits
    $error("hc_result_streamer: N_BITS must be a multiple of 8 and at least 8");
  end
  if (FIT_W > 16 || FIT_W < 1) begin : gen_bad_fit_w
    $error("hc_result_streamer: FIT_W must be in 1..16");
  end

  hc_stream_state_t  state;
  logic              done_q;
  logic [FIT_W-1:0]  fit_r;
  logic [N_BITS-1:0] sol_r;
  logic [IDX_W-1:0]  idx;

  logic              trig;
  logic              hs;
  logic [15:0]       fit16;
  logic [IDX_W-1:0]  idx_nxt;

  assign trig    = done_in & ~done_q;
  assign hs      = m_valid & m_ready;
  assign fit16   = 16'(fit_r);
  assign idx_nxt = idx + IDX_W'(1);

`ifdef HC_STREAM_CHECKSUM_EN
  logic [7:0] csum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= StIdle;
      done_q  <= 1'b0;
      fit_r   <= '0;
      sol_r   <= '0;
      idx     <= '0;
      m_data  <= 8'h00;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
`ifdef HC_STREAM_CHECKSUM_EN
      csum    <= 8'h00;
`endif
    end else begin
      done_q <= done_in;

      // A dropped edge outranks a clear in the same cycle.
      if (trig && busy) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end

`ifdef HC_STREAM_CHECKSUM_EN
      // Running XOR of every byte already accepted downstream.
      if (hs) begin
        csum <= csum ^ m_data;
      end
`endif

      unique case (state)
        StIdle: begin
          if (trig) begin
            fit_r   <= fitness_in;
            sol_r   <= solution_in;
            idx     <= '0;
            state   <= StHdr;
            m_data  <= SYNC_BYTE;
            m_valid <= 1'b1;
            m_last  <= 1'b0;
            busy    <= 1'b1;
`ifdef HC_STREAM_CHECKSUM_EN
            csum    <= 8'h00;
`endif
          end
        end

        StHdr: begin
          if (hs) begin
            state  <= StFitLo;
            m_data <= fit16[7:0];
          end
        end

        StFitLo: begin
          if (hs) begin
            state  <= StFitHi;
            m_data <= fit16[15:8];
          end
        end

        StFitHi: begin
          if (hs) begin
            state  <= StPayload;
            idx    <= '0;
            m_data <= sol_r[7:0];
            m_last <= (NB == 1) && !CSUM_EN;
          end
        end

        StPayload: begin
          if (hs) begin
            if (idx == IDX_LAST) begin
`ifdef HC_STREAM_CHECKSUM_EN
              state  <= StCsum;
              m_data <= csum ^ m_data;
              m_last <= 1'b1;
`else
              state   <= StIdle;
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              busy    <= 1'b0;
`endif
            end else begin
              idx    <= idx_nxt;
              m_data <= sol_r[{idx_nxt, 3'b000} +: 8];
              m_last <= (idx_nxt == IDX_LAST) && !CSUM_EN;
            end
          end
        end

`ifdef HC_STREAM_CHECKSUM_EN
        StCsum: begin
          if (hs) begin
            state   <= StIdle;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            busy    <= 1'b0;
          end
        end
`endif

        default: begin
          state   <= StIdle;
          m_valid <= 1'b0;
          m_last  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hc_result_streamer.sv
// Self-checking bench for hc_result_streamer with randomized frames and back-pressure.
// Expected frames come from a byte-list model built with plain arithmetic.
module tb_hc_result_streamer;

  localparam int N_BITS = 1024;
  localparam int FIT_W  = 12;
  localparam int NB     = N_BITS / 8;
`ifdef HC_STREAM_CHECKSUM_EN
  localparam int FRAME_LEN = 3 + NB + 1;
`else
  localparam int FRAME_LEN = 3 + NB;
`endif

  logic              clk;
  logic              rst_n;
  logic              done_in;
  logic [FIT_W-1:0]  fitness_in;
  logic [N_BITS-1:0] solution_in;
  logic [7:0]        m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic              busy;
  logic              overrun;
  logic              overrun_clr;

  hc_result_streamer #(
    .N_BITS (N_BITS),
    .FIT_W  (FIT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .done_in     (done_in),
    .fitness_in  (fitness_in),
    .solution_in (solution_in),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_last      (m_last),
    .busy        (busy),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] got_q[$];
  bit         got_last_q[$];
  logic [7:0] exp_q[$];
  int         stall_err;

  // Reference frame: sync, fitness low/high, solution bytes LSB first, optional XOR.
  function automatic void build_frame(input logic [FIT_W-1:0] fit, input logic [N_BITS-1:0] sol);
    logic [7:0] x;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(fit % 256));
    exp_q.push_back(8'(fit / 256));
    for (int k = 0; k < NB; k++) exp_q.push_back(8'(sol >> (8 * k)));
`ifdef HC_STREAM_CHECKSUM_EN
    x = 8'h00;
    foreach (exp_q[i]) x = x ^ exp_q[i];
    exp_q.push_back(x);
`endif
  endfunction

  // -1 when identical, -2 on a length difference, else the first differing index.
  function automatic int first_diff();
    if (got_q.size() != exp_q.size()) return -2;
    foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  // Index of the single m_last byte, -1 if none, -2 if more than one.
  function automatic int last_pos();
    int p = -1;
    foreach (got_last_q[i]) begin
      if (got_last_q[i]) begin
        if (p != -1) return -2;
        p = i;
      end
    end
    return p;
  endfunction

  task automatic rand_inputs(output logic [FIT_W-1:0] f, output logic [N_BITS-1:0] s);
    f = FIT_W'($urandom);
    for (int i = 0; i < N_BITS / 32; i++) s[32*i +: 32] = $urandom;
  endtask

  // Raise done_in and return just after the posedge that samples the edge.
  task automatic start_frame(input logic [FIT_W-1:0] fit, input logic [N_BITS-1:0] sol,
                             input bit hold);
    @(posedge clk); #1;
    fitness_in  = fit;
    solution_in = sol;
    done_in     = 1'b1;
    @(posedge clk); #1;
    if (!hold) done_in = 1'b0;
  endtask

  // Record handshakes (sampled on negedge), drive m_ready after each posedge, optionally
  // inject a one-cycle done pulse with fresh inputs at a given iteration.
  task automatic collect(input int ready_pct, input int max_cycles, input bit stop_on_last,
                         input int stop_after, input int inject_cycle, input bit clr_with_inject,
                         output bit timed_out);
    logic [7:0] pd;
    bit pl, stalled, hs_last;
    got_q.delete();
    got_last_q.delete();
    stall_err = 0;
    stalled   = 0;
    pd        = 8'h00;
    pl        = 0;
    timed_out = stop_on_last || (stop_after > 0);
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge clk);
      if (stalled && (m_valid !== 1'b1 || m_data !== pd || m_last !== pl)) stall_err++;
      stalled = 0;
      hs_last = 0;
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        got_q.push_back(m_data);
        got_last_q.push_back(m_last === 1'b1);
        hs_last = (m_last === 1'b1);
      end else if (m_valid === 1'b1) begin
        stalled = 1;
        pd      = m_data;
        pl      = m_last;
      end
      @(posedge clk); #1;
      if (c == inject_cycle) begin
        done_in = 1'b1;
        rand_inputs(fitness_in, solution_in);
        overrun_clr = clr_with_inject;
      end else if (c == inject_cycle + 1) begin
        done_in     = 1'b0;
        overrun_clr = 1'b0;
      end
      if (stop_on_last && hs_last) begin
        timed_out = 0;
        break;
      end
      if (stop_after > 0 && got_q.size() == stop_after) begin
        timed_out = 0;
        break;
      end
      m_ready = ($urandom_range(99) < ready_pct);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; done_in = 1'b0; fitness_in = '0; solution_in = '0;
    m_ready = 1'b0; overrun_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    n_tests++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL reset_m_data got %h want 00", m_data); end
    n_tests++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL reset_m_last got %b want 0", m_last); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", overrun); end
  endtask

  task automatic test_basic();
    logic [FIT_W-1:0] f;
    logic [N_BITS-1:0] s;
    bit to;
    int d, lp;
    f = 12'h3FF; s = '0; s[7:0] = 8'h81;
    build_frame(f, s);
    m_ready = 1'b1;
    start_frame(f, s, 0);
    n_tests++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL latency_valid got %b want 1", m_valid); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL latency_busy got %b want 1", busy); end
    n_tests++; if (m_data !== 8'hA5) begin n_fail++; $display("FAIL latency_sync got %h want a5", m_data); end
    collect(100, 300, 1, 0, -1, 0, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL basic_timeout got %0d bytes want %0d", got_q.size(), FRAME_LEN); end
    d = first_diff();
    n_tests++; if (d != -1) begin n_fail++; $display("FAIL basic_frame diff at %0d got len %0d want len %0d", d, got_q.size(), exp_q.size()); end
    n_tests++; if (got_q.size() > 3 && (got_q[1] !== 8'hFF || got_q[2] !== 8'h03 || got_q[3] !== 8'h81))
      begin n_fail++; $display("FAIL basic_head got %h %h %h want ff 03 81", got_q[1], got_q[2], got_q[3]); end
    lp = last_pos();
    n_tests++; if (lp != FRAME_LEN - 1) begin n_fail++; $display("FAIL basic_last got %0d want %0d", lp, FRAME_LEN - 1); end
    n_tests++; if (busy !== 1'b0 || m_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle got busy %b valid %b want 0 0", busy, m_valid); end
  endtask

  task automatic test_backpressure();
    logic [FIT_W-1:0] f;
    logic [N_BITS-1:0] s;
    bit to;
    int d, lp;
    for (int it = 0; it < 4; it++) begin
      if (it == 0) begin f = 12'h3FF; s = '0; s[7:0] = 8'h81; end
      else rand_inputs(f, s);
      build_frame(f, s);
      m_ready = $urandom_range(1);
      start_frame(f, s, 0);
      collect(50, 3000, 1, 0, -1, 0, to);
      d  = first_diff();
      lp = last_pos();
      n_tests++; if (to || d != -1) begin n_fail++; $display("FAIL bp_frame[%0d] timeout %b diff %0d got len %0d want len %0d", it, to, d, got_q.size(), exp_q.size()); end
      n_tests++; if (stall_err != 0) begin n_fail++; $display("FAIL bp_stable[%0d] got %0d unstable stalls want 0", it, stall_err); end
      n_tests++; if (lp != FRAME_LEN - 1) begin n_fail++; $display("FAIL bp_last[%0d] got %0d want %0d", it, lp, FRAME_LEN - 1); end
    end
  endtask

  task automatic test_overrun();
    logic [FIT_W-1:0] f;
    logic [N_BITS-1:0] s;
    bit to;
    int d;
    // Drop mid-frame: frame unchanged, overrun set.
    rand_inputs(f, s);
    build_frame(f, s);
    m_ready = 1'b1;
    start_frame(f, s, 0);
    collect(70, 3000, 1, 0, 20, 0, to);
    d = first_diff();
    n_tests++; if (to || d != -1) begin n_fail++; $display("FAIL ovr_frame timeout %b diff %0d", to, d); end
    n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set got %b want 1", overrun); end
    // Clear and a new drop in the same cycle: set wins.
    rand_inputs(f, s);
    build_frame(f, s);
    start_frame(f, s, 0);
    collect(70, 3000, 1, 0, 10, 1, to);
    d = first_diff();
    n_tests++; if (to || d != -1) begin n_fail++; $display("FAIL ovr_frame2 timeout %b diff %0d", to, d); end
    n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set_wins got %b want 1", overrun); end
    // Plain clear.
    @(posedge clk); #1 overrun_clr = 1'b1;
    @(posedge clk); #1 overrun_clr = 1'b0;
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got %b want 0", overrun); end
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_stays_clear got %b want 0", overrun); end
  endtask

  task automatic test_final_edge();
    logic [FIT_W-1:0] f;
    logic [N_BITS-1:0] s;
    bit to;
    int d;
    rand_inputs(f, s);
    build_frame(f, s);
    m_ready = 1'b1;
    start_frame(f, s, 0);
    // Edge sampled on the same posedge as the final handshake.
    collect(100, 300, 1, 0, FRAME_LEN - 2, 0, to);
    d = first_diff();
    n_tests++; if (to || d != -1) begin n_fail++; $display("FAIL final_edge_frame timeout %b diff %0d", to, d); end
    n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL final_edge_overrun got %b want 1", overrun); end
    collect(100, 200, 0, 0, -1, 0, to);
    n_tests++; if (got_q.size() != 0) begin n_fail++; $display("FAIL final_edge_no_frame got %0d bytes want 0", got_q.size()); end
    @(posedge clk); #1 overrun_clr = 1'b1;
    @(posedge clk); #1 overrun_clr = 1'b0;
  endtask

  task automatic test_held_high();
    logic [FIT_W-1:0] f;
    logic [N_BITS-1:0] s;
    bit to;
    int d, lp;
    rand_inputs(f, s);
    build_frame(f, s);
    m_ready = 1'b1;
    start_frame(f, s, 1);
    collect(100, 500, 0, 0, -1, 0, to);
    done_in = 1'b0;
    d  = first_diff();
    lp = last_pos();
    n_tests++; if (d != -1) begin n_fail++; $display("FAIL held_frame got %0d bytes want %0d (diff %0d)", got_q.size(), FRAME_LEN, d); end
    n_tests++; if (lp != FRAME_LEN - 1) begin n_fail++; $display("FAIL held_last got %0d want %0d", lp, FRAME_LEN - 1); end
  endtask

  task automatic test_reset_mid();
    logic [FIT_W-1:0] f;
    logic [N_BITS-1:0] s;
    bit to;
    int d;
    rand_inputs(f, s);
    m_ready = 1'b1;
    start_frame(f, s, 0);
    collect(100, 300, 0, 40, -1, 0, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL rst_mid_reach got %0d bytes want 40", got_q.size()); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (m_valid !== 1'b0 || busy !== 1'b0 || m_last !== 1'b0)
      begin n_fail++; $display("FAIL rst_mid_async got valid %b busy %b last %b want 0 0 0", m_valid, busy, m_last); end
    @(posedge clk); #1 rst_n = 1'b1;
    collect(100, 200, 0, 0, -1, 0, to);
    n_tests++; if (got_q.size() != 0) begin n_fail++; $display("FAIL rst_mid_abandon got %0d bytes want 0", got_q.size()); end
    rand_inputs(f, s);
    build_frame(f, s);
    start_frame(f, s, 0);
    collect(60, 3000, 1, 0, -1, 0, to);
    d = first_diff();
    n_tests++; if (to || d != -1) begin n_fail++; $display("FAIL rst_mid_new_frame timeout %b diff %0d", to, d); end
  endtask

`ifdef HC_STREAM_CHECKSUM_EN
  task automatic test_checksum();
    logic [N_BITS-1:0] s;
    bit to;
    s = '1;
    m_ready = 1'b1;
    start_frame(12'h001, s, 0);
    collect(100, 300, 1, 0, -1, 0, to);
    n_tests++; if (to || got_q.size() != 132) begin n_fail++; $display("FAIL csum_len got %0d want 132", got_q.size()); end
    n_tests++; if (got_q.size() > 0 && got_q[got_q.size()-1] !== 8'hA4)
      begin n_fail++; $display("FAIL csum_byte got %h want a4", got_q[got_q.size()-1]); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overrun();
    test_final_edge();
    test_held_high();
    test_reset_mid();
`ifdef HC_STREAM_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
